// File: rtl/wall_follower_fsm.sv
// Left-hand wall follower: Moore FSM from front/left sensors to (front, turn) motion commands.
// One registered step from sensor sample to command; no backpressure, sensors are sampled every cycle.
module wall_follower_fsm #(
    parameter int LOST_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic front_sensor,
    input  logic left_sensor,
    output logic front,
    output logic turn
);

    localparam int CW = (LOST_LIMIT < 2) ? 1 : $clog2(LOST_LIMIT + 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SEARCH = 3'd1;
    localparam logic [2:0] FOLLOW = 3'd2;
    localparam logic [2:0] ROTATE = 3'd3;
    localparam logic [2:0] CORNER = 3'd4;

    localparam logic [CW-1:0] CNT_LAST = CW'(LOST_LIMIT - 1);

    logic [2:0]    state;
    logic [2:0]    state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    // The counter only carries a value while staying in CORNER; every other
    // path (including entry into CORNER) leaves it at zero.
    always_comb begin
        state_next = IDLE;
        cnt_next   = '0;
        case (state)
            IDLE, SEARCH, ROTATE: begin
                if (front_sensor)      state_next = ROTATE;
                else if (left_sensor)  state_next = FOLLOW;
                else                   state_next = SEARCH;
            end
            FOLLOW: begin
                if (front_sensor)      state_next = ROTATE;
                else if (left_sensor)  state_next = FOLLOW;
                else                   state_next = CORNER;
            end
            CORNER: begin
                if (front_sensor)          state_next = ROTATE;
                else if (left_sensor)      state_next = FOLLOW;
                else if (cnt == CNT_LAST)  state_next = SEARCH;
                else begin
                    state_next = CORNER;
                    cnt_next   = cnt + CW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Commands depend on the state register alone, so reset clears them at once.
    always_comb begin
        front = 1'b0;
        turn  = 1'b0;
        case (state)
            SEARCH, FOLLOW: front = 1'b1;
            ROTATE:         turn  = 1'b1;
            CORNER: begin
                front = 1'b1;
                turn  = 1'b1;
            end
            default: begin
                front = 1'b0;
                turn  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_wall_follower_fsm.sv
// Directed-vector bench for wall_follower_fsm (LOST_LIMIT=4 main instance, LOST_LIMIT=1 corner instance).
module tb_wall_follower_fsm;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic front_sensor = 1'b0;
    logic left_sensor = 1'b0;
    logic front;
    logic turn;

    logic fs1 = 1'b0;
    logic ls1 = 1'b0;
    logic front1;
    logic turn1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    wall_follower_fsm #(.LOST_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .front_sensor(front_sensor), .left_sensor(left_sensor),
        .front(front), .turn(turn)
    );

    wall_follower_fsm #(.LOST_LIMIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .front_sensor(fs1), .left_sensor(ls1),
        .front(front1), .turn(turn1)
    );

    typedef struct {
        logic  fs;
        logic  ls;
        logic  ef;
        logic  et;
        string name;
    } vec_t;

    task automatic check(input string name, input logic af, input logic at,
                         input logic ef, input logic et);
        checks++;
        if (af !== ef || at !== et) begin
            errors++;
            $display("FAIL %s: got front,turn=%b,%b expected %b,%b", name, af, at, ef, et);
        end
    endtask

    // Drive sensors, take one rising edge, sample 1 time unit later.
    task automatic step(input logic fs, input logic ls, input string name,
                        input logic ef, input logic et);
        front_sensor = fs;
        left_sensor  = ls;
        @(posedge clk);
        #1;
        check(name, front, turn, ef, et);
    endtask

    task automatic step1(input logic fs, input logic ls, input string name,
                         input logic ef, input logic et);
        fs1 = fs;
        ls1 = ls;
        @(posedge clk);
        #1;
        check(name, front1, turn1, ef, et);
    endtask

    vec_t vecs[$];

    initial begin
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, "idle_to_search"});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, "search_to_rotate"});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, "rotate_to_search"});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, "search_to_follow"});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, "follow_hold1"});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, "follow_hold2"});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, "follow_hold3"});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b1, "both_high_rotate"});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, "rotate_hold"});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, "rotate_to_follow"});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, "follow_to_corner"});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, "corner_c1"});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, "corner_c2"});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, "corner_c3"});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, "corner_timeout"});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, "reacq_follow"});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, "reacq_corner_c0"});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, "reacq_corner_c1"});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, "reacq_corner_c2"});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, "corner_to_follow"});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, "restart_c0"});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, "restart_c1"});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, "restart_c2"});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, "restart_c3"});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, "restart_timeout"});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, "follow_again"});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, "corner_again"});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, "corner_to_rotate"});

        // Reset asserted from time 0: outputs must be 0,0 before any rising edge.
        #1;
        check("reset_no_clock", front, turn, 1'b0, 1'b0);
        check("reset_no_clock_l1", front1, turn1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("reset_held_edge", front, turn, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i].fs, vecs[i].ls, vecs[i].name, vecs[i].ef, vecs[i].et);

        // In ROTATE now; assert reset between edges.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_now", front, turn, 1'b0, 1'b0);
        front_sensor = 1'b1;
        left_sensor  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("reset_held_low", front, turn, 1'b0, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b0, "post_reset_rotate", 1'b0, 1'b1);
        step(1'b0, 1'b1, "post_reset_follow", 1'b1, 1'b0);

        // IDLE -> FOLLOW, told apart from SEARCH by the next (0,0) edge.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("reset_from_follow", front, turn, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b1, "idle_to_follow", 1'b1, 1'b0);
        step(1'b0, 1'b0, "idle_follow_corner", 1'b1, 1'b1);

        // LOST_LIMIT=1: CORNER lasts exactly one cycle.
        step1(1'b0, 1'b1, "l1_follow", 1'b1, 1'b0);
        step1(1'b0, 1'b0, "l1_corner", 1'b1, 1'b1);
        step1(1'b0, 1'b0, "l1_timeout", 1'b1, 1'b0);
        step1(1'b0, 1'b0, "l1_search_hold", 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/wall_follower_fsm.md
Name: wall_follower_fsm

Overview:
- Registered Moore state machine steering a left-hand wall-following robot.
- Each clock it samples a front obstacle sensor and a left wall sensor and drives two motion commands: front and turn.
- Top-level controller between the sensor front-end and the motor driver.

Parameters:
- LOST_LIMIT, 4: consecutive cycles in CORNER with no wall seen before returning to SEARCH. Legal range is 1 to 255.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- front_sensor  input  1  1 = obstacle directly ahead.
- left_sensor  input  1  1 = wall present on the left side.
- front  output  1  1 = drive forward.
- turn  output  1  1 = turn command; its meaning depends on front (see Behaviour).

Behaviour:
- Command encoding (front, turn):
  - 0,0 = stop.
  - 1,0 = straight ahead.
  - 0,1 = rotate right in place.
  - 1,1 = arc left while moving.
- Outputs are decoded from the state register only (Moore); there is no combinational path from inputs to outputs.
- Latency: inputs sampled at rising edge N determine the outputs visible right after edge N, i.e. one registered step.
- Reset:
  - rst_n=0 forces state IDLE, clears the lost counter, and sets front=0, turn=0 immediately, without waiting for a clock.
  - Release is synchronous to the next rising edge; the first edge with rst_n=1 applies the IDLE transitions.
  - Reset asserted mid-operation aborts any state at once.
- States, with outputs (front,turn), are listed below. Transitions are evaluated in the order listed; front_sensor always has top priority.
  - IDLE (0,0):
    - front_sensor=1 -> ROTATE
    - else left_sensor=1 -> FOLLOW
    - else -> SEARCH
  - SEARCH (1,0), no wall known:
    - front_sensor=1 -> ROTATE
    - else left_sensor=1 -> FOLLOW
    - else stay.
  - FOLLOW (1,0), wall on left:
    - front_sensor=1 -> ROTATE
    - else left_sensor=1 -> stay
    - else -> CORNER with lost counter cleared to 0.
  - ROTATE (0,1):
    - front_sensor=1 -> stay; rotation continues for as long as the obstacle is present.
    - else left_sensor=1 -> FOLLOW
    - else -> SEARCH
  - CORNER (1,1), wall lost, arcing left to reacquire it:
    - front_sensor=1 -> ROTATE
    - else left_sensor=1 -> FOLLOW
    - else if counter = LOST_LIMIT-1 -> SEARCH
    - else stay and increment counter.
- Lost counter:
  - Width is ceil(log2(LOST_LIMIT+1)), minimum 1 bit.
  - It is cleared on every entry into CORNER and in every other state, and never wraps.
- With LOST_LIMIT=1, CORNER lasts exactly one cycle when no sensor fires.
- Both sensors high at once: treated as front obstacle -> ROTATE.
- Inputs are assumed synchronous to clk; there is no internal synchronizer.
- State encoding is implementation's choice. Unused encodings must recover to IDLE on the next edge.

Test Plan:
- Reset then stimulus: rst_n=0 -> front=0, turn=0 with no clock. Release, then one edge with sensors (0,0) -> SEARCH, front=1, turn=0.
- Rotate and acquire: from SEARCH, edge with (front_sensor,left_sensor)=(1,0) -> (front,turn)=(0,1). Next edge (0,0) -> (1,0) SEARCH. Next edge (0,1) -> (1,0) FOLLOW; hold (0,1) for 3 edges -> stays (1,0).
- Priority: from FOLLOW, edge with (1,1) -> (0,1). Next (1,0) -> (0,1). Next (0,1) -> (1,0).
- Corner timeout (LOST_LIMIT=4): from FOLLOW, (0,0) for 1 edge -> (1,1). Three more (0,0) edges -> still (1,1). Fifth (0,0) edge -> (1,0) SEARCH.
- Corner reacquire: from CORNER after 2 cycles, edge with (0,1) -> FOLLOW (1,0). Then (0,0) -> CORNER with counter restarted from 0, still (1,1).
- Async reset mid-ROTATE: in ROTATE, pull rst_n low between edges -> outputs 0,0 immediately, and they stay 0,0 while low regardless of clk and sensors.
